mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage. It generalises the radix-2 divider to a configurable operand width and adds iterative multiply with configurable bits per cycle, MIPS-style signed/unsigned handling, divide-by-zero reporting and annul on flush. It drives the execute-stage stall and returns a {hi,lo} result for the HILO register path.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_div_step.sv | 20 ++
 rtl/mdu_iter.sv | 170 +++++++++++++++++
 tb/tb_mdu_iter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings seen on op_i and the controller state set.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not go negative.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_partRem,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qBit
);

    logic [WIDTH:0] w_diff;

    // The partial remainder is always below twice the divisor, so a set top bit
    // guarantees the subtraction succeeds and the result fits in WIDTH bits.
    assign w_diff = i_partRem - {1'b0, i_divisor};
    assign o_qBit = i_partRem[WIDTH] | ~w_diff[WIDTH];
    assign o_rem  = o_qBit ? w_diff[WIDTH-1:0] : i_partRem[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the execute stage: shift-add multiply,
// restoring divide, one sign-fix cycle, and a one-cycle done pulse with {hi,lo}.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);

    localparam int MUL_CYCLES = WIDTH / MUL_STEP;
    localparam int CNT_W      = $clog2(WIDTH + 1);

    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_isDiv;
    logic               r_negLo;
    logic               r_negHi;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_result;

    logic                      w_isDivOp;
    logic                      w_isSigned;
    logic                      w_signA;
    logic                      w_signB;
    logic [WIDTH-1:0]          w_absA;
    logic [WIDTH-1:0]          w_absB;
    logic [WIDTH+MUL_STEP-1:0] w_partial;
    logic [WIDTH+MUL_STEP-1:0] w_mulSum;
    logic [WIDTH-1:0]          w_divRem;
    logic                      w_qBit;
    logic [2*WIDTH-1:0]        w_prod;
    logic [2*WIDTH-1:0]        w_fixed;
    logic [WIDTH-1:0]          w_quoFix;
    logic [WIDTH-1:0]          w_remFix;

    assign w_isDivOp  = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    assign w_isSigned = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    assign w_signA    = w_isSigned & opa_i[WIDTH-1];
    assign w_signB    = w_isSigned & opb_i[WIDTH-1];
    assign w_absA     = w_signA ? -opa_i : opa_i;
    assign w_absB     = w_signB ? -opb_i : opb_i;

    // Multiplicand times the low MUL_STEP multiplier bits, built from shifted copies.
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (r_lo[j]) begin
                w_partial = w_partial + ({{MUL_STEP{1'b0}}, r_opnd} << j);
            end
        end
    end

    assign w_mulSum = w_partial + {{MUL_STEP{1'b0}}, r_hi};

    mdu_div_step #(
        .WIDTH(WIDTH)
    ) u_divStep (
        .i_partRem({r_hi, r_lo[WIDTH-1]}),
        .i_divisor(r_opnd),
        .o_rem    (w_divRem),
        .o_qBit   (w_qBit)
    );

    assign w_prod   = {r_hi, r_lo};
    assign w_quoFix = r_negLo ? -r_lo : r_lo;
    assign w_remFix = r_negHi ? -r_hi : r_hi;
    assign w_fixed  = r_isDiv ? {w_remFix, w_quoFix} : (r_negLo ? -w_prod : w_prod);

    // Stall asserts in the request cycle itself and drops in DONE so the result can retire.
    assign busy_o = !annul_i && ((r_state == ST_IDLE && start_i) ||
                                 r_state == ST_MUL || r_state == ST_DIV || r_state == ST_FIX);

    assign done_o        = r_done;
    assign div_by_zero_o = r_dbz;
    assign result_o      = r_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_isDiv  <= 1'b0;
            r_negLo  <= 1'b0;
            r_negHi  <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (annul_i) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i) begin
                            r_isDiv <= w_isDivOp;
                            r_count <= '0;
                            r_hi    <= '0;
                            if (w_isDivOp && opb_i == '0) begin
                                r_state  <= ST_DONE;
                                r_result <= {opa_i, {WIDTH{1'b1}}};
                                r_done   <= 1'b1;
                                r_dbz    <= 1'b1;
                            end else if (w_isDivOp) begin
                                r_state <= ST_DIV;
                                r_lo    <= w_absA;
                                r_opnd  <= w_absB;
                                r_negLo <= w_signA ^ w_signB;
                                r_negHi <= w_signA;
                            end else begin
                                r_state <= ST_MUL;
                                r_lo    <= w_absB;
                                r_opnd  <= w_absA;
                                r_negLo <= w_signA ^ w_signB;
                                r_negHi <= 1'b0;
                            end
                        end
                    end
                    ST_MUL: begin
                        r_hi    <= w_mulSum[WIDTH+MUL_STEP-1:MUL_STEP];
                        r_lo    <= {w_mulSum[MUL_STEP-1:0], r_lo[WIDTH-1:MUL_STEP]};
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(MUL_CYCLES - 1)) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_DIV: begin
                        r_hi    <= w_divRem;
                        r_lo    <= {r_lo[WIDTH-2:0], w_qBit};
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(WIDTH - 1)) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        r_result <= w_fixed;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: a 32-bit/step-2 instance and an 8-bit/step-4
// instance driven with directed and random operations against an arithmetic model.
module tb_mdu_iter;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          due;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        startA, annulA, busyA, doneA, dbzA;
    logic [1:0]  opA;
    logic [31:0] opaA, opbA;
    logic [63:0] resA;
    logic        startB, annulB, busyB, doneB, dbzB;
    logic [1:0]  opB;
    logic [7:0]  opaB, opbB;
    logic [15:0] resB;

    expEntry_t   qA[$];
    expEntry_t   qB[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cycleCnt   = 0;
    logic [63:0] lastA = '0;
    logic [63:0] lastB = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    mdu_iter #(.WIDTH(32), .MUL_STEP(2)) dutA (
        .clk(clk), .rst(rst_n), .start_i(startA), .op_i(opA), .annul_i(annulA),
        .opa_i(opaA), .opb_i(opbA), .busy_o(busyA), .done_o(doneA),
        .result_o(resA), .div_by_zero_o(dbzA)
    );

    mdu_iter #(.WIDTH(8), .MUL_STEP(4)) dutB (
        .clk(clk), .rst(rst_n), .start_i(startB), .op_i(opB), .annul_i(annulB),
        .opa_i(opaB), .opb_i(opbB), .busy_o(busyB), .done_o(doneB),
        .result_o(resB), .div_by_zero_o(dbzB)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on integers, MIPS truncating division.
    function automatic void refModel(input int w, input int step, input logic [1:0] op,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [63:0] res, output logic dbz, output int lat);
        logic [63:0] mask, pmask;
        longint      sa, sb, p, q, r;
        bit          isSigned;
        mask     = (64'd1 << w) - 64'd1;
        pmask    = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        isSigned = (op == OP_MULT) || (op == OP_DIV);
        sa = longint'(64'(a) & mask);
        sb = longint'(64'(b) & mask);
        if (isSigned && a[w-1]) sa = sa - (longint'(1) << w);
        if (isSigned && b[w-1]) sb = sb - (longint'(1) << w);
        dbz = 1'b0;
        if (op == OP_MULT || op == OP_MULTU) begin
            p   = sa * sb;
            res = 64'(p) & pmask;
            lat = w / step + 2;
        end else if ((64'(b) & mask) == 64'd0) begin
            res = ((64'(a) & mask) << w) | mask;
            dbz = 1'b1;
            lat = 1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = ((64'(r) & mask) << w) | (64'(q) & mask);
            lat = w + 2;
        end
    endfunction

    function automatic logic [31:0] pickOperand(input int w);
        logic [31:0] mask, v;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h1 << (w - 1);
            4:       v = ~(32'h1 << (w - 1));
            default: v = $urandom;
        endcase
        return v & mask;
    endfunction

    function automatic logic getBusy(input bit sel);
        return sel ? busyB : busyA;
    endfunction

    function automatic logic [63:0] getResult(input bit sel);
        return sel ? {48'h0, resB} : resA;
    endfunction

    task automatic driveInputs(input bit sel, input logic start, input logic annul,
                               input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            startB = start; annulB = annul; opB = op; opaB = a[7:0]; opbB = b[7:0];
        end else begin
            startA = start; annulA = annul; opA = op; opaA = a; opbA = b;
        end
    endtask

    // Issue one operation, push its expectation, and trace busy_o up to the DONE cycle.
    task automatic applyStimulus(input bit sel, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit holdStart);
        logic [63:0] res;
        logic        dbz;
        int          lat;
        expEntry_t   e;
        string       tag;
        tag = sel ? "w8" : "w32";
        refModel(sel ? 8 : 32, sel ? 4 : 2, op, a, b, res, dbz, lat);
        @(negedge clk);
        driveInputs(sel, 1'b1, 1'b0, op, a, b);
        e.res = res;
        e.dbz = dbz;
        e.due = cycleCnt + lat;
        if (sel) begin qB.push_back(e); lastB = res; end
        else     begin qA.push_back(e); lastA = res; end
        #1 checkOutput($sformatf("%s_busy_c0_op%0d", tag, op), 64'(getBusy(sel)), 64'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            driveInputs(sel, holdStart, 1'b0, op, a, b);
            #1 checkOutput($sformatf("%s_busy_c%0d_op%0d", tag, k, op), 64'(getBusy(sel)), (k < lat) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        driveInputs(sel, 1'b0, 1'b0, op, a, b);
    endtask

    // Start an operation that is flushed at cycle atCycle; annul_i is left high.
    task automatic annulAt(input bit sel, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int atCycle);
        logic [63:0] held;
        held = sel ? lastB : lastA;
        @(negedge clk);
        driveInputs(sel, 1'b1, 1'b0, op, a, b);
        #1 checkOutput("annul_busy_c0", 64'(getBusy(sel)), 64'd1);
        for (int k = 1; k <= atCycle; k++) begin
            @(negedge clk);
            driveInputs(sel, 1'b0, (k == atCycle), op, a, b);
            #1 checkOutput($sformatf("annul_busy_c%0d", k), 64'(getBusy(sel)), (k == atCycle) ? 64'd0 : 64'd1);
        end
        checkOutput("annul_result_held", getResult(sel), held);
    endtask

    task automatic monitorOne(input bit sel);
        logic        done, dbz;
        logic [63:0] res;
        expEntry_t   e;
        string       tag;
        tag  = sel ? "w8" : "w32";
        done = sel ? doneB : doneA;
        dbz  = sel ? dbzB : dbzA;
        res  = getResult(sel);
        if (done) begin
            if ((sel ? qB.size() : qA.size()) == 0) begin
                checkOutput({tag, "_unexpected_done"}, 64'(done), 64'd0);
            end else begin
                e = sel ? qB.pop_front() : qA.pop_front();
                checkOutput({tag, "_result"}, res, e.res);
                checkOutput({tag, "_div_by_zero"}, 64'(dbz), 64'(e.dbz));
                checkOutput({tag, "_latency_cycle"}, 64'(cycleCnt), 64'(e.due));
            end
        end else if (dbz) begin
            checkOutput({tag, "_stray_div_by_zero"}, 64'(dbz), 64'd0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                monitorOne(1'b0);
                monitorOne(1'b1);
            end
        end
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        rst_n = 1'b1;
        driveInputs(1'b0, 1'b0, 1'b0, OP_MULT, 32'h0, 32'h0);
        driveInputs(1'b1, 1'b0, 1'b0, OP_MULT, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_busy", 64'(busyA), 64'd0);
        checkOutput("reset_done", 64'(doneA), 64'd0);
        checkOutput("reset_result", resA, 64'd0);
        checkOutput("reset_dbz", 64'(dbzA), 64'd0);
        checkOutput("reset_result_w8", {48'h0, resB}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed operations");
        applyStimulus(1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        applyStimulus(1'b0, OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
        applyStimulus(1'b0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, OP_DIVU,  32'h0000_0005, 32'h0000_0000, 1'b0);
        applyStimulus(1'b0, OP_DIV,   32'h8000_0000, 32'h0000_0000, 1'b0);
        applyStimulus(1'b0, OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 1'b0);

        $display("[TB] annul sequences");
        annulAt(1'b0, OP_DIV, 32'h0000_1234, 32'h0000_0011, 10);
        applyStimulus(1'b0, OP_DIV, 32'hFFFF_F000, 32'h0000_0013, 1'b0);
        annulAt(1'b0, OP_MULT, 32'h0000_0123, 32'hFFFF_FF00, 17);
        applyStimulus(1'b0, OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        @(negedge clk);
        driveInputs(1'b0, 1'b1, 1'b1, OP_MULTU, 32'h3, 32'h4);
        #1 checkOutput("annul_idle_busy", 64'(busyA), 64'd0);
        applyStimulus(1'b0, OP_MULTU, 32'h0000_0003, 32'h0000_0005, 1'b0);

        $display("[TB] narrow instance");
        applyStimulus(1'b1, OP_MULT, 32'hFD, 32'h05, 1'b1);
        applyStimulus(1'b1, OP_DIV,  32'h80, 32'hFF, 1'b0);

        $display("[TB] random operations");
        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = pickOperand(32);
            b  = pickOperand(32);
            applyStimulus(1'b0, op, a, b, ($urandom_range(0, 3) == 0));
        end
        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = pickOperand(8);
            b  = pickOperand(8);
            applyStimulus(1'b1, op, a, b, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] reset during multiply");
        @(negedge clk);
        driveInputs(1'b0, 1'b1, 1'b0, OP_MULT, 32'h7654_3210, 32'h0000_0333);
        repeat (5) begin
            @(negedge clk);
            driveInputs(1'b0, 1'b0, 1'b0, OP_MULT, 32'h7654_3210, 32'h0000_0333);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midmul_reset_busy", 64'(busyA), 64'd0);
        checkOutput("midmul_reset_done", 64'(doneA), 64'd0);
        checkOutput("midmul_reset_result", resA, 64'd0);
        checkOutput("midmul_reset_dbz", 64'(dbzA), 64'd0);
        checkOutput("midmul_reset_result_w8", {48'h0, resB}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lastA = '0;
        lastB = '0;
        applyStimulus(1'b0, OP_DIVU, 32'h0000_0064, 32'h0000_0007, 1'b0);

        for (int i = 0; i < 200 && (qA.size() != 0 || qB.size() != 0); i++) @(negedge clk);
        checkOutput("pending_results", 64'(qA.size() + qB.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
